insn_prefetch: RTL and testbench

//  Instruction prefetch stage directly upstream of the stack CPU's fetch state.
//  - Issues word reads to instruction memory and buffers returned 16-bit words in a small FIFO.
//  - Presents the words to the CPU with a valid/ready handshake.
//  - Flushes and restarts at a new address when the CPU redirects the ip (jump/call).
//  - Decouples memory wait states from the fetch/word_cycle/byte_cycle sequencing.

---
 rtl/insn_prefetch_pkg.sv | 12 +
 rtl/insn_prefetch_fifo.sv | 57 +++++
 rtl/insn_prefetch.sv | 127 ++++++++++++
 tb/tb_insn_prefetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/insn_prefetch_pkg.sv
// rtl/insn_prefetch_pkg.sv - shared types for the instruction prefetch stage
package insn_prefetch_pkg;

  localparam int INSN_W = 16;

  typedef enum logic [1:0] {
    PF_IDLE         = 2'd0,
    PF_WAIT         = 2'd1,
    PF_WAIT_DISCARD = 2'd2
  } pf_state_t;

endpackage

// File: rtl/insn_prefetch_fifo.sv
// rtl/insn_prefetch_fifo.sv - sync FIFO holding {word, word address} entries
module insn_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = store[rd_ptr];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/insn_prefetch.sv
// rtl/insn_prefetch.sv - instruction prefetch: memory request FSM, fpc and word FIFO
module insn_prefetch
  import insn_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn_data,
  output logic [AW:0]       insn_addr,
  input  logic              insn_ready,
  input  logic              redir_valid,
  input  logic [AW:0]       redir_addr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSN_W + AW;

  pf_state_t     state;
  pf_state_t     state_nxt;
  logic [AW-1:0] fpc;
  logic [AW-1:0] fpc_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          mem_req_nxt;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          room_after_push;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_rdata;
  logic          redir_addr_unused;

  assign redir_addr_unused = redir_addr[0];
  assign fifo_pop          = insn_ready & ~fifo_empty & ~redir_valid;
  // While a request is in flight count <= DEPTH-1, so a same-cycle pop always leaves room.
  assign room_after_push   = fifo_pop | (fifo_count < CW'(DEPTH - 1));

  always_comb begin
    state_nxt    = state;
    fpc_nxt      = fpc;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    fifo_push    = 1'b0;
    case (state)
      PF_IDLE: begin
        if (!redir_valid && !fifo_full) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = fpc;
          fpc_nxt      = fpc + 1'b1;
          state_nxt    = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (redir_valid) begin
          if (mem_ack) begin
            mem_req_nxt = 1'b0;
            state_nxt   = PF_IDLE;
          end else begin
            state_nxt   = PF_WAIT_DISCARD;
          end
        end else if (mem_ack) begin
          fifo_push = 1'b1;
          if (room_after_push) begin
            mem_addr_nxt = fpc;
            fpc_nxt      = fpc + 1'b1;
          end else begin
            mem_req_nxt = 1'b0;
            state_nxt   = PF_IDLE;
          end
        end
      end
      PF_WAIT_DISCARD: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = PF_IDLE;
        end
      end
      default: begin
        mem_req_nxt = 1'b0;
        state_nxt   = PF_IDLE;
      end
    endcase
    if (redir_valid) fpc_nxt = redir_addr[AW:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PF_IDLE;
      fpc      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
    end
  end

  insn_prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redir_valid),
    .wdata ({mem_rdata, mem_addr}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign insn_valid = ~fifo_empty;
  assign insn_data  = fifo_rdata[EW-1:AW];
  assign insn_addr  = {fifo_rdata[AW-1:0], 1'b0};

endmodule

// File: tb/tb_insn_prefetch.sv
// tb/tb_insn_prefetch.sv - self-checking bench for insn_prefetch
module tb_insn_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        insn_valid;
  logic [15:0] insn_data;
  logic [15:0] insn_addr;
  logic        insn_ready;
  logic        redir_valid;
  logic [15:0] redir_addr;

  int checks = 0;
  int errors = 0;
  int lat;
  int wcnt;
  int ack_cnt;
  logic        pend;
  logic [14:0] pend_addr;
  logic [31:0] sb [$];

  typedef struct {
    logic [15:0] start;
    int          lat;
    int          max_cyc;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  insn_prefetch #(.DEPTH(4), .AW(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .insn_valid  (insn_valid),
    .insn_data   (insn_data),
    .insn_addr   (insn_addr),
    .insn_ready  (insn_ready),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr)
  );

  always #5 clk = ~clk;

  // memory: ack once the request has waited lat cycles, data = 0x8000 + word address
  assign mem_ack   = mem_req && (wcnt >= lat);
  assign mem_rdata = 16'h8000 + {1'b0, mem_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  always @(negedge clk) begin
    if (!rst_n)                  ack_cnt <= 0;
    else if (mem_req && mem_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_word();
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_word: got addr %0h data %0h, none expected", insn_addr, insn_data);
    end else begin
      exp = sb.pop_front();
      check("word_addr", 32'(insn_addr), 32'(exp[31:16]));
      check("word_data", 32'(insn_data), 32'(exp[15:0]));
    end
  endtask

  task automatic mon_proto();
    if (pend) begin
      check("req_held", 32'(mem_req), 32'd1);
      check("addr_stable", 32'(mem_addr), 32'(pend_addr));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && insn_valid && insn_ready && !redir_valid) mon_word();
    if (rst_n) mon_proto();
    pend      <= rst_n && mem_req && !mem_ack;
    pend_addr <= mem_addr;
  end

  task automatic drain(input string name, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_insn_valid"}, 32'(insn_valid), 32'd0);
    check({tag, "_insn_data"},  32'(insn_data),  32'd0);
    check({tag, "_insn_addr"},  32'(insn_addr),  32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'h0000, 0, 6,  64'h0000_0002_0004_0006, 64'h8000_8001_8002_8003};
    vecs[1] = '{16'hFFFC, 0, 6,  64'hFFFC_FFFE_0000_0002, 64'hFFFE_FFFF_8000_8001};
    vecs[2] = '{16'h0041, 2, 18, 64'h0040_0042_0044_0046, 64'h8020_8021_8022_8023};
    vecs[3] = '{16'h1235, 1, 13, 64'h1234_1236_1238_123A, 64'h891A_891B_891C_891D};
    vecs[4] = '{16'h8000, 3, 23, 64'h8000_8002_8004_8006, 64'hC000_C001_C002_C003};

    insn_ready  = 1'b0;
    redir_valid = 1'b0;
    redir_addr  = '0;
    lat         = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    lat   = 3;
    tick();
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);

    // stalled consumer: exactly DEPTH words fetched, then the request line idles
    repeat (40) tick();
    check("stall_acks", 32'(ack_cnt), 32'd4);
    check("stall_req", 32'(mem_req), 32'd0);
    check("stall_valid", 32'(insn_valid), 32'd1);
    check("stall_addr", 32'(insn_addr), 32'd0);
    check("stall_data", 32'(insn_data), 32'h8000);

    // redirect while the request to word 2 is still waiting
    do_reset();
    for (int c = 0; c < 60 && !(mem_req && mem_addr == 15'd2); c++) tick();
    check("wait_addr2", 32'(mem_req && mem_addr == 15'd2), 32'd1);
    redir_valid = 1'b1;
    redir_addr  = 16'h0041;
    sb.push_back({16'h0040, 16'h8020});
    sb.push_back({16'h0042, 16'h8021});
    tick();
    redir_valid = 1'b0;
    check("discard_req", 32'(mem_req), 32'd1);
    check("discard_addr", 32'(mem_addr), 32'd2);
    for (int c = 0; c < 60 && !(mem_req && mem_addr != 15'd2); c++) tick();
    check("redir_mem_addr", 32'(mem_addr), 32'h20);
    insn_ready = 1'b1;
    drain("redir_drain", cyc);
    insn_ready = 1'b0;

    for (int v = 0; v < 5; v++) begin
      lat         = vecs[v].lat;
      insn_ready  = 1'b1;
      redir_valid = 1'b1;
      redir_addr  = vecs[v].start;
      for (int i = 0; i < 4; i++)
        sb.push_back({vecs[v].exp_addr[63-16*i -: 16], vecs[v].exp_data[63-16*i -: 16]});
      tick();
      redir_valid = 1'b0;
      drain("vec_drain", cyc);
      check("vec_cycles", 32'(cyc <= vecs[v].max_cyc), 32'd1);
      insn_ready = 1'b0;
    end

    // redirect coinciding with mem_ack and a pop
    do_reset();
    lat = 2;
    for (int c = 0; c < 60 && !(mem_ack && insn_valid); c++) tick();
    check("wait_ack_valid", 32'(mem_ack && insn_valid), 32'd1);
    redir_valid = 1'b1;
    redir_addr  = 16'h0100;
    insn_ready  = 1'b1;
    sb.push_back({16'h0100, 16'h8080});
    sb.push_back({16'h0102, 16'h8081});
    tick();
    redir_valid = 1'b0;
    check("flush_empty", 32'(insn_valid), 32'd0);
    drain("ackredir_drain", cyc);
    insn_ready = 1'b0;

    // asynchronous reset in the middle of a wait
    do_reset();
    lat = 1;
    for (int c = 0; c < 60 && !(insn_valid && mem_req && !mem_ack); c++) tick();
    check("wait_midreq", 32'(insn_valid && mem_req && !mem_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    rst_n = 1'b1;
    tick();
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'd0);
    insn_ready = 1'b1;
    sb.push_back({16'h0000, 16'h8000});
    sb.push_back({16'h0002, 16'h8001});
    sb.push_back({16'h0004, 16'h8002});
    drain("restart_drain", cyc);
    insn_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
